redmule_tcdm_splitter: RTL and testbench

Splits one wide TCDM master port (DW bits) from the accelerator streamer into MP independent 32-bit TCDM lanes. Each lane has its own handshake.
- Lane grants may arrive on different cycles. Each grant is recorded, and the request is withdrawn per lane once granted.
- Lane responses may arrive on different cycles. They are buffered per lane, then merged into a single wide response.
- Sits between the accelerator top and the cluster interconnect, replacing AND-reduced gnt/r_valid binding.

---
 rtl/redmule_tcdm_splitter.sv | 168 ++++++++++++++++
 tb/tb_redmule_tcdm_splitter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_tcdm_splitter.sv
// Splits one wide TCDM master port into MP independent 32-bit TCDM lanes.
// Lane grants are collected individually. The wide grant fires in the cycle
// the last outstanding lane is granted. Lane responses are buffered per lane
// and merged into one wide response once every lane has a beat available.
module redmule_tcdm_splitter #(
  parameter int unsigned MP         = 4,
  parameter int unsigned DW         = 32 * MP,
  parameter int unsigned AW         = 32,
  parameter int unsigned RespDepth  = 2,
  parameter int unsigned LaneStride = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // wide side (accelerator streamer)
  input  logic             wide_req_i,
  output logic             wide_gnt_o,
  input  logic [AW-1:0]    wide_add_i,
  input  logic             wide_wen_i,
  input  logic [DW/8-1:0]  wide_be_i,
  input  logic [DW-1:0]    wide_data_i,
  output logic [DW-1:0]    wide_r_data_o,
  output logic             wide_r_valid_o,
  output logic             wide_r_opc_o,
  // lane side (cluster interconnect)
  output logic [MP-1:0]    lane_req_o,
  input  logic [MP-1:0]    lane_gnt_i,
  output logic [MP*AW-1:0] lane_add_o,
  output logic [MP-1:0]    lane_wen_o,
  output logic [MP*4-1:0]  lane_be_o,
  output logic [MP*32-1:0] lane_data_o,
  input  logic [MP*32-1:0] lane_r_data_i,
  input  logic [MP-1:0]    lane_r_valid_i,
  input  logic [MP-1:0]    lane_r_opc_i,
  // status
  output logic             idle_o,
  output logic             overflow_o
);

  localparam int unsigned CW = $clog2(RespDepth + 1);
  localparam int unsigned PW = (RespDepth > 1) ? $clog2(RespDepth) : 1;

  typedef struct packed {
    logic        opc;
    logic [31:0] data;
  } beat_t;

  logic [MP-1:0] gnt_q;
  logic [CW-1:0] outstanding_q;
  logic          overflow_q;

  beat_t         fifo_mem [MP][RespDepth];
  logic [PW-1:0] rd_ptr_q [MP];
  logic [PW-1:0] wr_ptr_q [MP];
  logic [CW-1:0] count_q  [MP];

  logic          issue_ok;
  logic [MP-1:0] lane_gnt_hit;
  logic [MP-1:0] empty, full, avail, opc_vec;
  logic [MP-1:0] pop, push, wr_en, drop;
  logic          dec_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RespDepth - 1)) ? '0 : p + PW'(1);
  endfunction

  // Request side: a lane asks until it is granted, then waits for the others.
  assign issue_ok     = outstanding_q < CW'(RespDepth);
  assign lane_req_o   = {MP{wide_req_i & issue_ok}} & ~gnt_q;
  assign lane_gnt_hit = lane_req_o & lane_gnt_i;
  assign wide_gnt_o   = wide_req_i & issue_ok & (&(gnt_q | lane_gnt_hit));

  assign lane_wen_o  = {MP{wide_wen_i}};
  assign lane_be_o   = wide_be_i;
  assign lane_data_o = wide_data_i;

  // Per-lane address: consecutive words starting at the wide address.
  always_comb begin
    for (int ii = 0; ii < MP; ii++) begin
      lane_add_o[ii*AW +: AW] = wide_add_i + AW'(ii * LaneStride);
    end
  end

  // Merge: take each lane's FIFO head, or bypass the live beat when empty.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
    wide_r_data_o = '0;
    opc_vec       = '0;
    empty         = '0;
    full          = '0;
    for (int ii = 0; ii < MP; ii++) begin
      empty[ii] = (count_q[ii] == '0);
      full[ii]  = (count_q[ii] == CW'(RespDepth));
      if (empty[ii]) begin
        wide_r_data_o[32*ii +: 32] = lane_r_data_i[32*ii +: 32];
        opc_vec[ii]                = lane_r_opc_i[ii];
      end else begin
        wide_r_data_o[32*ii +: 32] = fifo_mem[ii][rd_ptr_q[ii]].data;
        opc_vec[ii]                = fifo_mem[ii][rd_ptr_q[ii]].opc;
      end
    end
  end

  assign avail          = ~empty | lane_r_valid_i;
  assign wide_r_valid_o = &avail;
  assign wide_r_opc_o   = wide_r_valid_o & (|opc_vec);

  // A bypassed beat is consumed directly and never enters the FIFO.
  assign pop    = {MP{wide_r_valid_o}} & ~empty;
  assign push   = lane_r_valid_i & ~({MP{wide_r_valid_o}} & empty);
  assign wr_en  = push & (~full | pop);
  assign drop   = push & full & ~pop;
  assign dec_ok = wide_r_valid_o & (outstanding_q != '0);

  assign idle_o     = (outstanding_q == '0) & (gnt_q == '0) & (&empty);
  assign overflow_o = overflow_q;

  // Grant bookkeeping, outstanding counter and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q         <= '0;
      outstanding_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      gnt_q      <= wide_gnt_o ? '0 : (gnt_q | lane_gnt_hit);
      overflow_q <= overflow_q | (|drop);
      if (wide_gnt_o && !dec_ok) begin
        outstanding_q <= outstanding_q + CW'(1);
      end else if (!wide_gnt_o && dec_ok) begin
        outstanding_q <= outstanding_q - CW'(1);
      end
    end
  end

  // Per-lane FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int ii = 0; ii < MP; ii++) begin
        rd_ptr_q[ii] <= '0;
        wr_ptr_q[ii] <= '0;
        count_q[ii]  <= '0;
      end
    end else begin
      for (int ii = 0; ii < MP; ii++) begin
        if (pop[ii])   rd_ptr_q[ii] <= ptr_inc(rd_ptr_q[ii]);
        if (wr_en[ii]) wr_ptr_q[ii] <= ptr_inc(wr_ptr_q[ii]);
        if (wr_en[ii] && !pop[ii]) begin
          count_q[ii] <= count_q[ii] + CW'(1);
        end else if (!wr_en[ii] && pop[ii]) begin
          count_q[ii] <= count_q[ii] - CW'(1);
        end
      end
    end
  end

  // FIFO storage.
  // NOTE: storage is not reset; the reset pointers/counts mark it empty, and
  // leaving it out of reset lets it map onto plain flops or RAM.
  always_ff @(posedge clk_i) begin
    for (int ii = 0; ii < MP; ii++) begin
      if (wr_en[ii]) begin
        fifo_mem[ii][wr_ptr_q[ii]] <= '{opc: lane_r_opc_i[ii], data: lane_r_data_i[32*ii +: 32]};
      end
    end
  end

endmodule

// File: tb/tb_redmule_tcdm_splitter.sv
// Directed bench for redmule_tcdm_splitter (MP=4, RespDepth=2).
// Each record holds one cycle of stimulus and the expected combinational
// outputs, sampled mid-cycle before the next rising edge.
module tb_redmule_tcdm_splitter;

  localparam int MP = 4;
  localparam int DW = 32 * MP;
  localparam int AW = 32;

  logic             clk, rst_n;
  logic             wide_req, wide_gnt, wide_wen, wide_r_valid, wide_r_opc;
  logic [AW-1:0]    wide_add;
  logic [DW/8-1:0]  wide_be;
  logic [DW-1:0]    wide_data, wide_r_data;
  logic [MP-1:0]    lane_req, lane_gnt, lane_wen, lane_r_valid, lane_r_opc;
  logic [MP*AW-1:0] lane_add;
  logic [MP*4-1:0]  lane_be;
  logic [MP*32-1:0] lane_data, lane_r_data;
  logic             idle, overflow;

  redmule_tcdm_splitter #(
    .MP(MP), .DW(DW), .AW(AW), .RespDepth(2), .LaneStride(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wide_req_i(wide_req), .wide_gnt_o(wide_gnt), .wide_add_i(wide_add),
    .wide_wen_i(wide_wen), .wide_be_i(wide_be), .wide_data_i(wide_data),
    .wide_r_data_o(wide_r_data), .wide_r_valid_o(wide_r_valid), .wide_r_opc_o(wide_r_opc),
    .lane_req_o(lane_req), .lane_gnt_i(lane_gnt), .lane_add_o(lane_add),
    .lane_wen_o(lane_wen), .lane_be_o(lane_be), .lane_data_o(lane_data),
    .lane_r_data_i(lane_r_data), .lane_r_valid_i(lane_r_valid), .lane_r_opc_i(lane_r_opc),
    .idle_o(idle), .overflow_o(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          req;
    logic [31:0]   add;
    logic          wen;
    logic [MP-1:0] gnt;
    logic [MP-1:0] rv;
    logic [MP-1:0] opc;
    logic [DW-1:0] rdata;
    logic          e_gnt;
    logic [MP-1:0] e_lreq;
    logic          e_rv;
    logic          e_opc;
    logic [DW-1:0] e_rdata;
    logic          e_idle;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack4(input logic [31:0] d3, input logic [31:0] d2,
                                          input logic [31:0] d1, input logic [31:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mk(input logic req, input logic [31:0] add, input logic wen,
                              input logic [MP-1:0] gnt, input logic [MP-1:0] rv,
                              input logic [MP-1:0] opc, input logic [DW-1:0] rdata,
                              input logic e_gnt, input logic [MP-1:0] e_lreq,
                              input logic e_rv, input logic e_opc,
                              input logic [DW-1:0] e_rdata, input logic e_idle);
    vec_t v;
    v.req = req; v.add = add; v.wen = wen; v.gnt = gnt; v.rv = rv; v.opc = opc;
    v.rdata = rdata; v.e_gnt = e_gnt; v.e_lreq = e_lreq; v.e_rv = e_rv;
    v.e_opc = e_opc; v.e_rdata = e_rdata; v.e_idle = e_idle;
    return v;
  endfunction

  task automatic drive_idle();
    wide_req = 1'b0; wide_add = '0; wide_wen = 1'b0;
    lane_gnt = '0; lane_r_valid = '0; lane_r_opc = '0; lane_r_data = '0;
  endtask

  // Apply one record at posedge+1, compare at posedge+6, return at next posedge+1.
  task automatic step(input vec_t v, input string tag);
    logic [AW-1:0] exp_add;
    wide_req = v.req; wide_add = v.add; wide_wen = v.wen;
    lane_gnt = v.gnt; lane_r_valid = v.rv; lane_r_opc = v.opc; lane_r_data = v.rdata;
    #5;
    check({tag, ".wide_gnt"}, DW'(wide_gnt), DW'(v.e_gnt));
    check({tag, ".lane_req"}, DW'(lane_req), DW'(v.e_lreq));
    check({tag, ".r_valid"},  DW'(wide_r_valid), DW'(v.e_rv));
    check({tag, ".r_opc"},    DW'(wide_r_opc), DW'(v.e_opc));
    check({tag, ".idle"},     DW'(idle), DW'(v.e_idle));
    if (v.e_rv) check({tag, ".r_data"}, wide_r_data, v.e_rdata);
    if (v.req) begin
      for (int ii = 0; ii < MP; ii++) begin
        exp_add = v.add + 32'(ii * 4);
        check($sformatf("%s.lane_add%0d", tag, ii), DW'(lane_add[ii*AW +: AW]), DW'(exp_add));
      end
      check({tag, ".lane_wen"},  DW'(lane_wen), DW'({MP{v.wen}}));
      check({tag, ".lane_be"},   DW'(lane_be), DW'(wide_be));
      check({tag, ".lane_data"}, DW'(lane_data), wide_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".wide_gnt"}, DW'(wide_gnt), '0);
    check({tag, ".lane_req"}, DW'(lane_req), '0);
    check({tag, ".r_valid"},  DW'(wide_r_valid), '0);
    check({tag, ".idle"},     DW'(idle), DW'(1));
    check({tag, ".overflow"}, DW'(overflow), '0);
  endtask

  localparam int NV = 13;
  vec_t vecs [NV];

  logic [DW-1:0] basic_d, r5_d, r7_d, r7_exp, wr_d, x1, x2, stale_d, clean_d, zero_d;

  initial begin
    basic_d = pack4(32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0F0F_0F00);
    r5_d    = pack4(32'hEEEE_0003, 32'hEEEE_0002, 32'h1111_1111, 32'hEEEE_0000);
    r7_d    = pack4(32'h0000_0073, 32'h0000_0072, 32'hBADB_AD00, 32'h0000_0070);
    r7_exp  = pack4(32'h0000_0073, 32'h0000_0072, 32'h1111_1111, 32'h0000_0070);
    wr_d    = pack4(32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000);
    x1      = pack4(32'hA1A1_0003, 32'hA1A1_0002, 32'hA1A1_0001, 32'hA1A1_0000);
    x2      = pack4(32'hB2B2_0003, 32'hB2B2_0002, 32'hB2B2_0001, 32'hB2B2_0000);
    stale_d = pack4(32'h0, 32'hDEAD_0002, 32'h0, 32'h0);
    clean_d = pack4(32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000);
    zero_d  = '0;

    //                req addr          wen gnt      rv       opc      rdata    gnt lreq     rv opc exp      idle
    // single-cycle read, response one cycle later
    vecs[0]  = mk(1, 32'h1000, 1, 4'b1111, 4'b0000, 4'b0000, zero_d,  1, 4'b1111, 0, 0, zero_d,  1);
    vecs[1]  = mk(0, 32'h0000, 0, 4'b0000, 4'b1111, 4'b0000, basic_d, 0, 4'b0000, 1, 0, basic_d, 0);
    vecs[2]  = mk(0, 32'h0000, 0, 4'b0000, 4'b0000, 4'b0000, zero_d,  0, 4'b0000, 0, 0, zero_d,  1);
    // staggered grants: lane0, lane2, none, lanes 1+3
    vecs[3]  = mk(1, 32'h2000, 1, 4'b0001, 4'b0000, 4'b0000, zero_d,  0, 4'b1111, 0, 0, zero_d,  1);
    vecs[4]  = mk(1, 32'h2000, 1, 4'b0100, 4'b0000, 4'b0000, zero_d,  0, 4'b1110, 0, 0, zero_d,  0);
    vecs[5]  = mk(1, 32'h2000, 1, 4'b0000, 4'b0000, 4'b0000, zero_d,  0, 4'b1010, 0, 0, zero_d,  0);
    vecs[6]  = mk(1, 32'h2000, 1, 4'b1010, 4'b0000, 4'b0000, zero_d,  1, 4'b1010, 0, 0, zero_d,  0);
    // next (write) request sees all lanes requesting again: grant state cleared
    vecs[7]  = mk(1, 32'h2400, 0, 4'b1111, 4'b0000, 4'b0000, zero_d,  1, 4'b1111, 0, 0, zero_d,  0);
    // staggered responses: lane1 early (buffered), rest two cycles later
    vecs[8]  = mk(0, 32'h0000, 0, 4'b0000, 4'b0010, 4'b0000, r5_d,    0, 4'b0000, 0, 0, zero_d,  0);
    vecs[9]  = mk(0, 32'h0000, 0, 4'b0000, 4'b0000, 4'b0000, zero_d,  0, 4'b0000, 0, 0, zero_d,  0);
    vecs[10] = mk(0, 32'h0000, 0, 4'b0000, 4'b1101, 4'b0010, r7_d,    0, 4'b0000, 1, 0, r7_exp,  0);
    // write response with lane 2 error flag
    vecs[11] = mk(0, 32'h0000, 0, 4'b0000, 4'b1111, 4'b0100, wr_d,    0, 4'b0000, 1, 1, wr_d,    0);
    vecs[12] = mk(0, 32'h0000, 0, 4'b0000, 4'b0000, 4'b0000, zero_d,  0, 4'b0000, 0, 0, zero_d,  1);

    wide_be   = 16'hC3A5;
    wide_data = pack4(32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001, 32'hD0D0_0000);
    drive_idle();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Outstanding limit: two in flight block the third until a response retires.
    step(mk(1, 32'h4000, 1, 4'b1111, 4'b0000, 4'b0000, zero_d, 1, 4'b1111, 0, 0, zero_d, 1), "lim.t1");
    step(mk(1, 32'h4010, 1, 4'b1111, 4'b0000, 4'b0000, zero_d, 1, 4'b1111, 0, 0, zero_d, 0), "lim.t2");
    step(mk(1, 32'h4020, 1, 4'b1111, 4'b0000, 4'b0000, zero_d, 0, 4'b0000, 0, 0, zero_d, 0), "lim.blk");
    step(mk(1, 32'h4020, 1, 4'b1111, 4'b1111, 4'b0000, x1,     0, 4'b0000, 1, 0, x1,     0), "lim.r1");
    // third grant and second response together: count stays at one
    step(mk(1, 32'h4020, 1, 4'b1111, 4'b1111, 4'b0000, x2,     1, 4'b1111, 1, 0, x2,     0), "lim.t3r2");
    step(mk(1, 32'h4030, 1, 4'b1111, 4'b0000, 4'b0000, zero_d, 1, 4'b1111, 0, 0, zero_d, 0), "lim.t4");
    step(mk(1, 32'h4040, 1, 4'b1111, 4'b0000, 4'b0000, zero_d, 0, 4'b0000, 0, 0, zero_d, 0), "lim.blk2");
    step(mk(0, 32'h0000, 0, 4'b0000, 4'b1111, 4'b0000, x1,     0, 4'b0000, 1, 0, x1,     0), "lim.r3");
    step(mk(0, 32'h0000, 0, 4'b0000, 4'b1111, 4'b0000, x2,     0, 4'b0000, 1, 0, x2,     0), "lim.r4");
    step(mk(0, 32'h0000, 0, 4'b0000, 4'b0000, 4'b0000, zero_d, 0, 4'b0000, 0, 0, zero_d, 1), "lim.idle");

    // Overflow: three unsolicited lane-0 beats into a two-deep FIFO.
    for (int k = 0; k < 3; k++) begin
      step(mk(0, 32'h0, 0, 4'b0000, 4'b0001, 4'b0000, zero_d, 0, 4'b0000, 0, 0, zero_d, k == 0),
           $sformatf("ovf.push%0d", k));
      check($sformatf("ovf.pre%0d", k), DW'(overflow), DW'(k == 2));
    end
    for (int k = 0; k < 2; k++) begin
      step(mk(0, 32'h0, 0, 4'b0000, 4'b0000, 4'b0000, zero_d, 0, 4'b0000, 0, 0, zero_d, 0),
           $sformatf("ovf.hold%0d", k));
      check($sformatf("ovf.sticky%0d", k), DW'(overflow), DW'(1));
    end
    rst_n = 1'b0;
    #2;
    check_reset_outputs("ovf.rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-transaction: two lanes granted, one lane-2 beat buffered.
    step(mk(1, 32'h5000, 1, 4'b0011, 4'b0000, 4'b0000, zero_d,  0, 4'b1111, 0, 0, zero_d, 1), "mid.g");
    step(mk(1, 32'h5000, 1, 4'b0000, 4'b0100, 4'b0000, stale_d, 0, 4'b1100, 0, 0, zero_d, 0), "mid.b");
    drive_idle();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("mid.rst");
    @(posedge clk);
    #1;
    check_reset_outputs("mid.rst2");
    rst_n = 1'b1;
    step(mk(1, 32'h6000, 1, 4'b1111, 4'b0000, 4'b0000, zero_d,  1, 4'b1111, 0, 0, zero_d,  1), "cln.g");
    step(mk(0, 32'h0000, 0, 4'b0000, 4'b1111, 4'b0000, clean_d, 0, 4'b0000, 1, 0, clean_d, 0), "cln.r");
    step(mk(0, 32'h0000, 0, 4'b0000, 4'b0000, 4'b0000, zero_d,  0, 4'b0000, 0, 0, zero_d,  1), "cln.idle");
    check("cln.overflow", DW'(overflow), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
